read_32bit_pattern_source: RTL

READ_32BIT_PATTERN_SOURCE -- requirements
Module: read_32bit_pattern_source

---
 rtl/read_32bit_pattern_source.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/read_32bit_pattern_source.sv
// ---------------------------------------------------------------------------
// read_32bit_pattern_source
//
// Generates a selectable 32-bit test pattern into a first-word-fall-through
// prefetch buffer that a pipe-out reader drains one word per strobe. It also
// keeps a run timer and read/underflow statistics.
//
// Ports
//   okClk           in   1   sole clock, rising edge
//   reset           in   1   asynchronous active-high reset
//   reset_pattern   in   1   pulse: reload generator from mode/seed, flush buffer
//   start_timer     in   1   pulse: enable generation, start timer
//   stop_timer      in   1   pulse: disable generation, stop timer (wins over start)
//   pattern_mode    in   2   00 counter, 01 walking-one, 10 LFSR32, 11 alternating
//   pattern_seed    in  32   first word emitted after a generator reload
//   pipe_out_read   in   1   read strobe, one word consumed per asserted cycle
//   pipe_out_data   out 32   head word of the buffer, zero when empty
//   clk_counts      out 64   cycles spent running (wraps)
//   words_read      out 32   successful reads (saturating)
//   underflow_count out 32   reads issued while empty (saturating)
//   fill_level      out  9   buffer occupancy, 0..DEPTH
//   running         out  1   generator enabled
// ---------------------------------------------------------------------------
module read_32bit_pattern_source #(
  parameter int DEPTH = 16
) (
  input  logic        okClk,
  input  logic        reset,
  input  logic        reset_pattern,
  input  logic        start_timer,
  input  logic        stop_timer,
  input  logic [1:0]  pattern_mode,
  input  logic [31:0] pattern_seed,
  input  logic        pipe_out_read,
  output logic [31:0] pipe_out_data,
  output logic [63:0] clk_counts,
  output logic [31:0] words_read,
  output logic [31:0] underflow_count,
  output logic [8:0]  fill_level,
  output logic        running
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [8:0]  DEPTH_LVL = 9'(DEPTH);
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic {IDLE, RUN} state_t;

  // First word of a sequence; zero seeds would lock up walking-one and LFSR.
  function automatic logic [31:0] seed_word(input logic [1:0] mode,
                                            input logic [31:0] seed);
    logic [31:0] w;
    case (mode)
      2'b00:   w = seed;
      2'b01:   w = (seed == 32'h0) ? 32'h0000_0001 : seed;
      2'b10:   w = (seed == 32'h0) ? 32'hFFFF_FFFF : seed;
      default: w = 32'hAAAA_AAAA;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] next_word(input logic [1:0] mode,
                                            input logic [31:0] w);
    logic [31:0] n;
    case (mode)
      2'b00:   n = w + 32'd1;
      2'b01:   n = {w[30:0], w[31]};
      // Galois right shift: feedback is the bit shifted out of position 0.
      2'b10:   n = (w >> 1) ^ (w[0] ? LFSR_MASK : 32'h0);
      default: n = ~w;
    endcase
    return n;
  endfunction

  // ---------------------------------------------------------------- control
  state_t state, state_next;
  logic   count_en;

  always_ff @(posedge okClk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    state_next = state;
    case (state)
      IDLE: if (start_timer && !stop_timer) state_next = RUN;
      RUN:  if (stop_timer)                 state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
    // Timer covers the start cycle but not the stop cycle.
    count_en = (state_next == RUN);
  end

  assign running = (state == RUN);

  // -------------------------------------------------------------- generator
  // seed_pending stays high through reset so mode/seed are taken from the
  // inputs on the first edge after release; the word is visible combinationally
  // meanwhile, so a push on that edge already carries the seed.
  logic        seed_pending;
  logic [1:0]  gen_mode, cur_mode;
  logic [31:0] gen_word, cur_word;
  logic        push, pop;

  assign cur_mode = seed_pending ? pattern_mode : gen_mode;
  assign cur_word = seed_pending ? seed_word(pattern_mode, pattern_seed) : gen_word;
  assign push     = running && (fill_level < DEPTH_LVL) && !reset_pattern;
  assign pop      = pipe_out_read && (fill_level != 9'd0);

  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      seed_pending <= 1'b1;
      gen_mode     <= 2'b00;
      gen_word     <= 32'h0;
    end else begin
      seed_pending <= 1'b0;
      if (reset_pattern) begin
        gen_mode <= pattern_mode;
        gen_word <= seed_word(pattern_mode, pattern_seed);
      end else begin
        gen_mode <= cur_mode;
        gen_word <= push ? next_word(cur_mode, cur_word) : cur_word;
      end
    end
  end

  // ----------------------------------------------------------------- buffer
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // NOTE: storage is not reset; fill_level gates every observable read.
  always_ff @(posedge okClk) begin
    if (push) mem[wr_ptr] <= cur_word;
  end

  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= 9'd0;
    end else if (reset_pattern) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= 9'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill_level <= fill_level + 9'd1;
        2'b01:   fill_level <= fill_level - 9'd1;
        default: fill_level <= fill_level;
      endcase
    end
  end

  assign pipe_out_data = (fill_level != 9'd0) ? mem[rd_ptr] : 32'h0;

  // --------------------------------------------------------------- counters
  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      clk_counts      <= 64'd0;
      words_read      <= 32'd0;
      underflow_count <= 32'd0;
    end else begin
      if (count_en) clk_counts <= clk_counts + 64'd1;
      if (pop && (words_read != 32'hFFFF_FFFF))
        words_read <= words_read + 32'd1;
      if (pipe_out_read && (fill_level == 9'd0) && (underflow_count != 32'hFFFF_FFFF))
        underflow_count <= underflow_count + 32'd1;
    end
  end

endmodule
